reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
// - Parametrised multi-port integer register file for the pipelined RV32 core; replaces the fixed 2R/1W file.
// - Adds a second write port, per-register scoreboard busy bits for hazard detection and a sequenced clear engine.
// - Sits in the ID stage: decode reads operands and allocates destinations; WB (and a late unit) write back.
// PARAMETERS
// - XLEN    32  data width of each register
// - NREGS   32  register count, power of two, >=4; register 0 hard-wired to zero
// - NUM_RD   2  number of read ports, 1..4
// - AW      $clog2(NREGS)  address width (derived, localparam)
// PORTS
// - clk        in   1              rising-edge clock
// - reset_n    in   1              asynchronous, active-low reset
// - rd_addr    in   NUM_RD*AW      packed read addresses, port k at [k*AW +: AW]
// - rd_data    out  NUM_RD*XLEN    packed read data, port k at [k*XLEN +: XLEN]
// - rd_busy    out  NUM_RD         busy bit of the register addressed by port k
// - wr0_en     in   1              write port 0 enable (WB stage)
// - wr0_addr   in   AW             write port 0 address
// - wr0_data   in   XLEN           write port 0 data
// - wr1_en     in   1              write port 1 enable (late unit, higher priority)
// - wr1_addr   in   AW             write port 1 address
// - wr1_data   in   XLEN           write port 1 data
// - alloc_en   in   1              mark destination register pending
// - alloc_addr in   AW             destination register to mark
// - busy_vec   out  NREGS          scoreboard bits, bit 0 always 0
// - clr_req    in   1              start a sequenced clear of all registers
// - clr_busy   out  1              clear engine active (writes/allocs ignored)
// - clr_done   out  1              one-cycle pulse when clear completes
// - dbg_addr   in   AW             debug/trace read address
// - dbg_data   out  XLEN           debug read data (never bypassed)
// BEHAVIOUR
// - Reset (reset_n=0, async): all registers 0, busy_vec 0, FSM IDLE, clr_busy 0, clr_done 0, clear counter 0.
// - Reads combinational, 0-cycle latency; address 0 returns 0 on every read port and dbg_data.
// - Writes take effect at rising clk; address 0 writes dropped; port enables independent.
// - wr0 and wr1 same address same cycle: wr1 data stored, wr0 discarded.
// - Scoreboard: alloc_en sets busy[alloc_addr] at next edge; an enabled write clears busy[wr_addr].
// - Alloc and write to same address same cycle: busy stays 1 (new producer wins); data still written.
// - alloc_addr 0 ignored; busy_vec[0] constant 0. rd_busy[k] = busy_vec[rd_addr[k]] (0 for addr 0).
// - FSM states IDLE, CLEAR, DONE:
//   - IDLE: clr_req=1 -> CLEAR, counter<=1, busy_vec<=0 at same edge.
//   - CLEAR: each cycle reg[counter]<=0, counter++; when counter==NREGS-1 -> DONE after that write.
//   - DONE: clr_done=1 for exactly one cycle -> IDLE.
//   - clr_busy=1 in CLEAR and DONE; wr0/wr1/alloc ignored; clr_req ignored outside IDLE.
//   - Clear latency: clr_req sampled at edge 0, clr_done high in cycle NREGS, writes accepted again from cycle NREGS+1.
// - reset_n asserted mid-clear: immediate return to IDLE with full reset state; no clr_done pulse.
// CONFIGURATION
// - RF_BYPASS_EN defined: read port k returns same-cycle write data when its address matches an enabled write
//   (wr1 over wr0), and rd_busy[k] reports 0 for that address unless alloc to it in the same cycle.
// - RF_BYPASS_EN undefined: reads return stored value; write visible from the cycle after the edge.
// - Neither setting affects dbg_data, address 0, or behaviour while clr_busy=1 (no bypass during clear).
// TESTING
// - Reset then read all addresses on every port -> 0; busy_vec=0; clr_done=0.
// - wr0 x5=0xAAAA_0001 and wr1 x5=0x5555_0002 same cycle -> next cycle x5 reads 0x5555_0002.
// - wr0_en to x0 with 0xFFFF_FFFF -> x0 still reads 0 on every port and dbg_data.
// - alloc x7, next cycle rd_busy=1 on port reading x7; wr0 x7=0x12 with alloc x7 same cycle -> busy stays 1, data 0x12.
// - Write x3=0x33 with rd_addr0=3 same cycle -> 0x33 with RF_BYPASS_EN, old value 0 without.
// - Load x1..x31 nonzero, pulse clr_req -> clr_busy NREGS cycles, clr_done one pulse cycle NREGS, all regs 0; repeat with reset_n low mid-clear -> no clr_done.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Bundle of read, write, scoreboard, clear and debug signals for the multi-port register file.
// master = decode/writeback side driving requests, slave = the register file itself.
interface reg_file_mp_if #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NUM_RD = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NUM_RD*AW-1:0]   rd_addr;
   logic [NUM_RD*XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]      rd_busy;

   logic                   wr0_en;
   logic [AW-1:0]          wr0_addr;
   logic [XLEN-1:0]        wr0_data;
   logic                   wr1_en;
   logic [AW-1:0]          wr1_addr;
   logic [XLEN-1:0]        wr1_data;

   logic                   alloc_en;
   logic [AW-1:0]          alloc_addr;
   logic [NREGS-1:0]       busy_vec;

   logic                   clr_req;
   logic                   clr_busy;
   logic                   clr_done;

   logic [AW-1:0]          dbg_addr;
   logic [XLEN-1:0]        dbg_data;

   modport master (
      output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
             alloc_en, alloc_addr, clr_req, dbg_addr,
      input  rd_data, rd_busy, busy_vec, clr_busy, clr_done, dbg_data
   );

   modport slave (
      input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
             alloc_en, alloc_addr, clr_req, dbg_addr,
      output rd_data, rd_busy, busy_vec, clr_busy, clr_done, dbg_data
   );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port RV32 integer register file: NUM_RD combinational reads, two write ports, busy scoreboard
// and a sequenced clear engine. Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NUM_RD = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   reg_file_mp_if.slave rf
);
   localparam int AW = $clog2(NREGS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [AW-1:0]   clr_cnt_reg, clr_cnt_next;

   logic            clr_busy_int;
   logic            clr_done_int;
   logic            clear_active;
   logic            accept;
   logic            clr_start;

   logic [XLEN-1:0] reg_q  [NREGS];
   logic            busy_q [NREGS];

   // ---------------- clear engine ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= ST_IDLE;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (rf.clr_req) begin
               state_next   = ST_CLEAR;
               clr_cnt_next = AW'(1);
            end
         end
         ST_CLEAR: begin
            clr_cnt_next = clr_cnt_reg + AW'(1);
            if (clr_cnt_reg == AW'(NREGS - 1)) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      clr_busy_int = 1'b0;
      clr_done_int = 1'b0;
      clear_active = 1'b0;
      case (state_reg)
         ST_CLEAR: begin
            clr_busy_int = 1'b1;
            clear_active = 1'b1;
         end
         ST_DONE: begin
            clr_busy_int = 1'b1;
            clr_done_int = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Writes and allocations are only honoured while the clear engine is idle.
   assign accept    = !clr_busy_int;
   assign clr_start = accept && rf.clr_req;

   assign rf.clr_busy = clr_busy_int;
   assign rf.clr_done = clr_done_int;

   // ---------------- register storage and scoreboard ----------------
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
         assign reg_q[gi]  = '0;
         assign busy_q[gi] = 1'b0;
      end else begin : g_live
         logic [XLEN-1:0] data_reg;
         logic            busy_reg;
         logic            hit0, hit1, hit_alloc, hit_clr;

         assign hit0      = accept && rf.wr0_en   && (rf.wr0_addr   == AW'(gi));
         assign hit1      = accept && rf.wr1_en   && (rf.wr1_addr   == AW'(gi));
         assign hit_alloc = accept && rf.alloc_en && (rf.alloc_addr == AW'(gi));
         assign hit_clr   = clear_active && (clr_cnt_reg == AW'(gi));

         // The late unit (port 1) overrides WB on an address collision.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               data_reg <= '0;
            end else if (hit_clr) begin
               data_reg <= '0;
            end else if (hit1) begin
               data_reg <= rf.wr1_data;
            end else if (hit0) begin
               data_reg <= rf.wr0_data;
            end
         end

         // A new producer allocated in the same cycle as a writeback keeps the register pending.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               busy_reg <= 1'b0;
            end else if (clr_start) begin
               busy_reg <= 1'b0;
            end else if (hit_alloc) begin
               busy_reg <= 1'b1;
            end else if (hit0 || hit1) begin
               busy_reg <= 1'b0;
            end
         end

         assign reg_q[gi]  = data_reg;
         assign busy_q[gi] = busy_reg;
      end
   end

   logic [NREGS-1:0] busy_pack;
   always_comb begin
      busy_pack = '0;
      for (int i = 0; i < NREGS; i++) begin
         busy_pack[i] = busy_q[i];
      end
   end
   assign rf.busy_vec = busy_pack;

   // ---------------- read ports ----------------
   logic [XLEN-1:0] rd_data_arr [NUM_RD];
   logic            rd_busy_arr [NUM_RD];

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rf.rd_addr[gi*AW +: AW];
`ifdef RF_BYPASS_EN
      logic byp0, byp1, alloc_same;
      assign byp1       = accept && rf.wr1_en   && (rf.wr1_addr   == ra) && (ra != '0);
      assign byp0       = accept && rf.wr0_en   && (rf.wr0_addr   == ra) && (ra != '0);
      assign alloc_same = accept && rf.alloc_en && (rf.alloc_addr == ra);
      assign rd_data_arr[gi] = byp1 ? rf.wr1_data : (byp0 ? rf.wr0_data : reg_q[ra]);
      assign rd_busy_arr[gi] = (byp1 || byp0) ? alloc_same : busy_q[ra];
`else
      assign rd_data_arr[gi] = reg_q[ra];
      assign rd_busy_arr[gi] = busy_q[ra];
`endif
   end

   logic [NUM_RD*XLEN-1:0] rd_data_pack;
   logic [NUM_RD-1:0]      rd_busy_pack;
   always_comb begin
      rd_data_pack = '0;
      rd_busy_pack = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_data_pack[k*XLEN +: XLEN] = rd_data_arr[k];
         rd_busy_pack[k]              = rd_busy_arr[k];
      end
   end
   assign rf.rd_data = rd_data_pack;
   assign rf.rd_busy = rd_busy_pack;

   // Debug/trace port always shows the stored value.
   assign rf.dbg_data = reg_q[rf.dbg_addr];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and random checks of reg_file_mp against an array-based reference model of the
// register file, scoreboard and clear sequence.
module tb_reg_file_mp;
   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int NUM_RD = 2;
   localparam int AW     = $clog2(NREGS);

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD)) rf();

   reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rf      (rf)
   );

   // Reference model: register contents, pending bits, and the clear phase
   // (0 = idle, 1..NREGS-1 = next register to zero, NREGS = done cycle).
   logic [XLEN-1:0] m_regs [NREGS];
   bit              m_busy [NREGS];
   int              m_clr;

   int total = 0;
   int bad   = 0;
   bit obs_clr_busy, obs_clr_done;

   function automatic void model_reset();
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_clr = 0;
   endfunction

   function automatic void model_edge();
      if (!reset_n) begin
         model_reset();
         return;
      end
      if (m_clr == 0) begin
         if (rf.wr0_en && rf.wr0_addr != 0) begin
            m_regs[rf.wr0_addr] = rf.wr0_data;
            m_busy[rf.wr0_addr] = 1'b0;
         end
         if (rf.wr1_en && rf.wr1_addr != 0) begin
            m_regs[rf.wr1_addr] = rf.wr1_data;
            m_busy[rf.wr1_addr] = 1'b0;
         end
         if (rf.alloc_en && rf.alloc_addr != 0) m_busy[rf.alloc_addr] = 1'b1;
         if (rf.clr_req) begin
            for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
            m_clr = 1;
         end
      end else if (m_clr < NREGS) begin
         m_regs[m_clr] = '0;
         m_clr++;
      end else begin
         m_clr = 0;
      end
   endfunction

   function automatic logic [XLEN-1:0] exp_rd(int a);
      logic [XLEN-1:0] v;
      v = (a == 0) ? '0 : m_regs[a];
`ifdef RF_BYPASS_EN
      if (m_clr == 0 && a != 0) begin
         if (rf.wr1_en && int'(rf.wr1_addr) == a)      v = rf.wr1_data;
         else if (rf.wr0_en && int'(rf.wr0_addr) == a) v = rf.wr0_data;
      end
`endif
      return v;
   endfunction

   function automatic logic exp_busy(int a);
      logic b;
      b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef RF_BYPASS_EN
      if (m_clr == 0 && a != 0 &&
          ((rf.wr1_en && int'(rf.wr1_addr) == a) || (rf.wr0_en && int'(rf.wr0_addr) == a)))
         b = rf.alloc_en && int'(rf.alloc_addr) == a;
`endif
      return b;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [NREGS-1:0] ev;
      for (int k = 0; k < NUM_RD; k++) begin
         int a;
         a = int'(rf.rd_addr[k*AW +: AW]);
         chk($sformatf("rd_data[%0d] x%0d", k, a), 64'(rf.rd_data[k*XLEN +: XLEN]), 64'(exp_rd(a)));
         chk($sformatf("rd_busy[%0d] x%0d", k, a), 64'(rf.rd_busy[k]), 64'(exp_busy(a)));
      end
      for (int i = 0; i < NREGS; i++) ev[i] = m_busy[i];
      chk("busy_vec", 64'(rf.busy_vec), 64'(ev));
      chk("clr_busy", 64'(rf.clr_busy), 64'(m_clr != 0));
      chk("clr_done", 64'(rf.clr_done), 64'(m_clr == NREGS));
      chk($sformatf("dbg_data x%0d", rf.dbg_addr), 64'(rf.dbg_data),
          64'((rf.dbg_addr == 0) ? '0 : m_regs[rf.dbg_addr]));
      obs_clr_busy = rf.clr_busy;
      obs_clr_done = rf.clr_done;
   endtask

   // Inputs are set 1ns after a rising edge; outputs are checked 2ns after it.
   task automatic tick();
      #1;
      check_all();
      $display("t=%0t rst_n=%b wr0=%b x%0d=%h wr1=%b x%0d=%h alloc=%b x%0d clr_req=%b clr_busy=%b clr_done=%b",
               $time, reset_n, rf.wr0_en, rf.wr0_addr, rf.wr0_data, rf.wr1_en, rf.wr1_addr,
               rf.wr1_data, rf.alloc_en, rf.alloc_addr, rf.clr_req, rf.clr_busy, rf.clr_done);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      rf.wr0_en   = 1'b0;
      rf.wr1_en   = 1'b0;
      rf.alloc_en = 1'b0;
      rf.clr_req  = 1'b0;
   endtask

   task automatic set_rd(int k, int a);
      rf.rd_addr[k*AW +: AW] = AW'(a);
   endtask

   task automatic load_all();
      for (int a = 1; a < NREGS; a++) begin
         rf.wr1_en   = 1'b1;
         rf.wr1_addr = AW'(a);
         rf.wr1_data = 32'hC000_0000 | XLEN'(a);
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin
      int n_busy, n_done, done_at;

      idle_inputs();
      rf.rd_addr    = '0;
      rf.dbg_addr   = '0;
      rf.wr0_addr   = '0;
      rf.wr0_data   = '0;
      rf.wr1_addr   = '0;
      rf.wr1_data   = '0;
      rf.alloc_addr = '0;
      model_reset();
      @(posedge clk);
      #1;

      // Reset state: every address on every port and the debug port reads 0.
      for (int a = 0; a < NREGS; a++) begin
         for (int k = 0; k < NUM_RD; k++) set_rd(k, a);
         rf.dbg_addr = AW'(a);
         tick();
      end
      chk("reset clr_done", 64'(rf.clr_done), 64'(0));
      chk("reset busy_vec", 64'(rf.busy_vec), 64'(0));
      reset_n = 1'b1;

      // Both write ports hit x5 in the same cycle: port 1 wins.
      rf.wr0_en = 1'b1; rf.wr0_addr = 5; rf.wr0_data = 32'hAAAA_0001;
      rf.wr1_en = 1'b1; rf.wr1_addr = 5; rf.wr1_data = 32'h5555_0002;
      set_rd(0, 5);
      tick();
      idle_inputs();
      #1;
      chk("x5 wr1 wins", 64'(rf.rd_data[0 +: XLEN]), 64'(32'h5555_0002));
      tick();

      // Writes to x0 are dropped.
      rf.wr0_en = 1'b1; rf.wr0_addr = 0; rf.wr0_data = 32'hFFFF_FFFF;
      set_rd(0, 0); set_rd(1, 0); rf.dbg_addr = 0;
      tick();
      idle_inputs();
      #1;
      chk("x0 port0", 64'(rf.rd_data[0 +: XLEN]), 64'(0));
      chk("x0 port1", 64'(rf.rd_data[XLEN +: XLEN]), 64'(0));
      chk("x0 dbg", 64'(rf.dbg_data), 64'(0));
      tick();

      // Scoreboard: alloc x7, then write and re-alloc x7 in the same cycle.
      rf.alloc_en = 1'b1; rf.alloc_addr = 7;
      set_rd(1, 7); rf.dbg_addr = 7;
      tick();
      idle_inputs();
      #1;
      chk("x7 busy after alloc", 64'(rf.rd_busy[1]), 64'(1));
      rf.wr0_en = 1'b1; rf.wr0_addr = 7; rf.wr0_data = 32'h12;
      rf.alloc_en = 1'b1; rf.alloc_addr = 7;
      tick();
      idle_inputs();
      #1;
      chk("x7 busy kept", 64'(rf.rd_busy[1]), 64'(1));
      chk("x7 data", 64'(rf.rd_data[XLEN +: XLEN]), 64'(32'h12));
      chk("x7 dbg", 64'(rf.dbg_data), 64'(32'h12));
      tick();

      // Same-cycle read of a register being written.
      rf.wr0_en = 1'b1; rf.wr0_addr = 3; rf.wr0_data = 32'h33;
      set_rd(0, 3);
      #1;
`ifdef RF_BYPASS_EN
      chk("x3 same cycle", 64'(rf.rd_data[0 +: XLEN]), 64'(32'h33));
`else
      chk("x3 same cycle", 64'(rf.rd_data[0 +: XLEN]), 64'(0));
`endif
      tick();
      idle_inputs();
      #1;
      chk("x3 next cycle", 64'(rf.rd_data[0 +: XLEN]), 64'(32'h33));
      tick();

      // Full clear sequence with write/alloc attempts during it.
      load_all();
      rf.clr_req = 1'b1;
      tick();
      rf.clr_req = 1'b0;
      n_busy = 0; n_done = 0; done_at = -1;
      for (int c = 1; c <= NREGS + 3; c++) begin
         rf.wr0_en     = (c <= NREGS);
         rf.wr0_addr   = AW'(NREGS - 1);
         rf.wr0_data   = 32'hDEAD_BEEF;
         rf.alloc_en   = 1'b1;
         rf.alloc_addr = AW'(NREGS - 2);
         set_rd(0, c % NREGS);
         rf.dbg_addr   = AW'(c % NREGS);
         tick();
         if (obs_clr_busy) n_busy++;
         if (obs_clr_done) begin
            n_done++;
            done_at = c;
         end
      end
      idle_inputs();
      chk("clr_busy cycles", 64'(n_busy), 64'(NREGS));
      chk("clr_done pulses", 64'(n_done), 64'(1));
      chk("clr_done cycle", 64'(done_at), 64'(NREGS));
      #1;
      chk("alloc after clear", 64'(rf.busy_vec[NREGS-2]), 64'(1));
      for (int a = 1; a < NREGS; a++) begin
         rf.dbg_addr = AW'(a);
         #1;
         chk($sformatf("cleared x%0d", a), 64'(rf.dbg_data), 64'(0));
         tick();
      end

      // Reset in the middle of a clear: no done pulse afterwards.
      load_all();
      rf.clr_req = 1'b1;
      tick();
      rf.clr_req = 1'b0;
      repeat (10) tick();
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("mid-clear reset clr_busy", 64'(rf.clr_busy), 64'(0));
      tick();
      reset_n = 1'b1;
      n_done = 0;
      for (int c = 0; c < NREGS + 3; c++) begin
         rf.dbg_addr = AW'(c % NREGS);
         tick();
         if (obs_clr_done) n_done++;
      end
      chk("no clr_done after reset", 64'(n_done), 64'(0));

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         rf.wr0_en     = ($urandom_range(0, 1) == 1);
         rf.wr0_addr   = AW'($urandom_range(0, NREGS - 1));
         rf.wr0_data   = $urandom();
         rf.wr1_en     = ($urandom_range(0, 3) == 0);
         rf.wr1_addr   = AW'($urandom_range(0, NREGS - 1));
         rf.wr1_data   = $urandom();
         rf.alloc_en   = ($urandom_range(0, 1) == 1);
         rf.alloc_addr = AW'($urandom_range(0, NREGS - 1));
         rf.clr_req    = ($urandom_range(0, 59) == 0);
         for (int k = 0; k < NUM_RD; k++) set_rd(k, int'($urandom_range(0, NREGS - 1)));
         rf.dbg_addr   = AW'($urandom_range(0, NREGS - 1));
         tick();
      end
      idle_inputs();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
